npn_canon4: RTL and testbench

- Sequential NPN canonicaliser for 4-input Boolean functions.
- Sits directly upstream of the exact-synthesis MIG library lookup. It converts an arbitrary 16-bit truth table into its NPN class representative plus the transform that maps the input function onto it.
- Downstream logic uses the canonical value to select the stored exact MIG and the transform to rewire and invert its inputs and output.
- Exhaustive search: 24 permutations × 16 input-negation masks, with both output polarities evaluated each cycle.

---
 rtl/npn_canon4.sv | 155 +++++++++++++++
 tb/tb_npn_canon4.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npn_canon4.sv
// Sequential NPN canonicaliser for 4-input truth tables: searches all 384
// (permutation, input-negation) steps, both output polarities per step.
module npn_canon4 #(
  parameter bit          EARLY_EXIT = 1'b0,
  parameter int unsigned TT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TT_W-1:0] in_tt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TT_W-1:0] canon_tt,
  output logic [4:0]      perm_idx,
  output logic [3:0]      in_neg,
  output logic            out_neg,
  output logic            busy
);

  localparam int unsigned CNT_W     = 9;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(383);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [TT_W-1:0]  r_f;
  logic [TT_W:0]    r_best;
  logic [CNT_W-1:0] r_cnt;

  logic [7:0]       w_lut;
  logic [3:0]       w_n;
  logic [TT_W-1:0]  w_g0;
  logic [TT_W-1:0]  w_g1;
  logic [TT_W-1:0]  w_cand;
  logic             w_cand_o;
  logic             w_better;
  logic             w_last;

  // Lexicographic permutation table, packed as {p(0),p(1),p(2),p(3)}.
  function automatic logic [7:0] perm_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    perm_lut = {2'd0, 2'd1, 2'd2, 2'd3};
      5'd1:    perm_lut = {2'd0, 2'd1, 2'd3, 2'd2};
      5'd2:    perm_lut = {2'd0, 2'd2, 2'd1, 2'd3};
      5'd3:    perm_lut = {2'd0, 2'd2, 2'd3, 2'd1};
      5'd4:    perm_lut = {2'd0, 2'd3, 2'd1, 2'd2};
      5'd5:    perm_lut = {2'd0, 2'd3, 2'd2, 2'd1};
      5'd6:    perm_lut = {2'd1, 2'd0, 2'd2, 2'd3};
      5'd7:    perm_lut = {2'd1, 2'd0, 2'd3, 2'd2};
      5'd8:    perm_lut = {2'd1, 2'd2, 2'd0, 2'd3};
      5'd9:    perm_lut = {2'd1, 2'd2, 2'd3, 2'd0};
      5'd10:   perm_lut = {2'd1, 2'd3, 2'd0, 2'd2};
      5'd11:   perm_lut = {2'd1, 2'd3, 2'd2, 2'd0};
      5'd12:   perm_lut = {2'd2, 2'd0, 2'd1, 2'd3};
      5'd13:   perm_lut = {2'd2, 2'd0, 2'd3, 2'd1};
      5'd14:   perm_lut = {2'd2, 2'd1, 2'd0, 2'd3};
      5'd15:   perm_lut = {2'd2, 2'd1, 2'd3, 2'd0};
      5'd16:   perm_lut = {2'd2, 2'd3, 2'd0, 2'd1};
      5'd17:   perm_lut = {2'd2, 2'd3, 2'd1, 2'd0};
      5'd18:   perm_lut = {2'd3, 2'd0, 2'd1, 2'd2};
      5'd19:   perm_lut = {2'd3, 2'd0, 2'd2, 2'd1};
      5'd20:   perm_lut = {2'd3, 2'd1, 2'd0, 2'd2};
      5'd21:   perm_lut = {2'd3, 2'd1, 2'd2, 2'd0};
      5'd22:   perm_lut = {2'd3, 2'd2, 2'd0, 2'd1};
      5'd23:   perm_lut = {2'd3, 2'd2, 2'd1, 2'd0};
      default: perm_lut = {2'd0, 2'd1, 2'd2, 2'd3};
    endcase
  endfunction

  assign w_lut = perm_lut(r_cnt[8:4]);
  assign w_n   = r_cnt[3:0];

  // Candidate for the current step: g0(m) = f(k), bit p(i) of k = m[i] ^ n[i].
  always_comb begin : cand_eval
    logic [3:0] mv;
    logic [3:0] k;
    w_g0 = '0;
    mv   = '0;
    k    = '0;
    for (int m = 0; m < 16; m++) begin
      mv = 4'(m);
      k  = '0;
      for (int i = 0; i < 4; i++) begin
        k[w_lut[(3-i)*2 +: 2]] = mv[i] ^ w_n[i];
      end
      w_g0[m] = r_f[k];
    end
  end

  // o = 0 wins ties, so polarity 1 is taken only when strictly smaller.
  assign w_g1     = ~w_g0;
  assign w_cand_o = (w_g1 < w_g0);
  assign w_cand   = w_cand_o ? w_g1 : w_g0;
  assign w_better = ({1'b0, w_cand} < r_best);
  assign w_last   = (r_cnt == LAST_STEP) || (EARLY_EXIT && (w_cand == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_f       <= '0;
      r_best    <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      canon_tt  <= '0;
      perm_idx  <= '0;
      in_neg    <= '0;
      out_neg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_f      <= in_tt;
            r_best   <= {1'b1, {TT_W{1'b0}}};
            r_cnt    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_better) begin
            r_best   <= {1'b0, w_cand};
            canon_tt <= w_cand;
            perm_idx <= r_cnt[8:4];
            in_neg   <= w_n;
            out_neg  <= w_cand_o;
          end
          if (w_last) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npn_canon4.sv
// Directed and small random bench for npn_canon4, with a software NPN model.
module tb_npn_canon4;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_neg, busy;
  logic [15:0] in_tt, canon_tt;
  logic [4:0]  perm_idx;
  logic [3:0]  in_neg;

  logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_out_neg, e_busy;
  logic [15:0] e_in_tt, e_canon_tt;
  logic [4:0]  e_perm_idx;
  logic [3:0]  e_in_neg;

  int checks   = 0;
  int failures = 0;
  int pt[24][4];

  always #5 clk = ~clk;

  npn_canon4 #(.EARLY_EXIT(1'b0), .TT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tt(in_tt),
    .out_valid(out_valid), .out_ready(out_ready), .canon_tt(canon_tt),
    .perm_idx(perm_idx), .in_neg(in_neg), .out_neg(out_neg), .busy(busy)
  );

  npn_canon4 #(.EARLY_EXIT(1'b1), .TT_W(16)) dut_ee (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_tt(e_in_tt),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .canon_tt(e_canon_tt),
    .perm_idx(e_perm_idx), .in_neg(e_in_neg), .out_neg(e_out_neg), .busy(e_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // g(m) = f(k) ^ o where bit pt[p][i] of k is m[i] ^ n[i].
  function automatic logic [15:0] apply_tf(input logic [15:0] f, input int p,
                                           input logic [3:0] n, input logic o);
    logic [15:0] g;
    logic [3:0]  mv;
    logic [3:0]  k;
    g = '0;
    for (int m = 0; m < 16; m++) begin
      mv = 4'(m);
      k  = '0;
      for (int i = 0; i < 4; i++) k[pt[p][i]] = mv[i] ^ n[i];
      g[m] = f[k] ^ o;
    end
    return g;
  endfunction

  task automatic npn_model(input logic [15:0] f, output logic [15:0] c, output int bp,
                           output logic [3:0] bn, output logic bo);
    logic [16:0] best;
    logic [15:0] g;
    best = 17'h10000;
    c = '0; bp = 0; bn = '0; bo = 1'b0;
    for (int p = 0; p < 24; p++)
      for (int n = 0; n < 16; n++)
        for (int o = 0; o < 2; o++) begin
          g = apply_tf(f, p, 4'(n), 1'(o));
          if ({1'b0, g} < best) begin
            best = {1'b0, g}; c = g; bp = p; bn = 4'(n); bo = 1'(o);
          end
        end
  endtask

  task automatic run_main(input logic [15:0] tt);
    int cyc;
    in_tt = tt; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("search_in_ready", 32'(in_ready), 0);
    check("search_busy", 32'(busy), 1);
    cyc = 0;
    while (!out_valid && cyc < 500) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 384);
    check("done_in_ready", 32'(in_ready), 0);
    check("done_busy", 32'(busy), 0);
  endtask

  task automatic release_main();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 0);
    check("release_in_ready", 32'(in_ready), 1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] c, input int p,
                              input logic [3:0] n, input logic o);
    check($sformatf("%s_canon", tag), 32'(canon_tt), 32'(c));
    check($sformatf("%s_perm", tag), 32'(perm_idx), 32'(p));
    check($sformatf("%s_in_neg", tag), 32'(in_neg), 32'(n));
    check($sformatf("%s_out_neg", tag), 32'(out_neg), 32'(o));
  endtask

  task automatic check_vs_model(input string tag, input logic [15:0] tt);
    logic [15:0] mc;
    int          mp;
    logic [3:0]  mn;
    logic        mo;
    npn_model(tt, mc, mp, mn, mo);
    check_result(tag, mc, mp, mn, mo);
    check($sformatf("%s_reapply", tag),
          32'(apply_tf(tt, int'(perm_idx), in_neg, out_neg)), 32'(mc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          idx;
    logic [15:0] snap_c;
    logic [4:0]  snap_p;
    logic [3:0]  snap_n;
    logic        snap_o;
    logic        seen;
    int          cyc;
    logic [15:0] rtt;

    idx = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++)
            if (a != b && a != c && a != d && b != c && b != d && c != d) begin
              pt[idx][0] = a; pt[idx][1] = b; pt[idx][2] = c; pt[idx][3] = d;
              idx++;
            end

    rst = 1'b1;
    in_valid = 1'b0; in_tt = '0; out_ready = 1'b0;
    e_in_valid = 1'b0; e_in_tt = '0; e_out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check_result("rst", 16'h0000, 0, 4'h0, 1'b0);
    check("rst_ee_in_ready", 32'(e_in_ready), 1);

    // Early-exit instance: zero candidate on the very first step.
    e_in_tt = 16'h0000; e_in_valid = 1'b1;
    tick();
    e_in_valid = 1'b0;
    check("ee0_busy", 32'(e_busy), 1);
    check("ee0_out_valid_early", 32'(e_out_valid), 0);
    tick();
    check("ee0_out_valid", 32'(e_out_valid), 1);
    check("ee0_canon", 32'(e_canon_tt), 32'h0000);
    check("ee0_perm", 32'(e_perm_idx), 0);
    check("ee0_out_neg", 32'(e_out_neg), 0);
    e_out_ready = 1'b1; tick(); e_out_ready = 1'b0;
    check("ee0_release", 32'(e_in_ready), 1);

    e_in_tt = 16'hFFFF; e_in_valid = 1'b1;
    tick();
    e_in_valid = 1'b0;
    tick();
    check("eeF_out_valid", 32'(e_out_valid), 1);
    check("eeF_canon", 32'(e_canon_tt), 32'h0000);
    check("eeF_in_neg", 32'(e_in_neg), 0);
    check("eeF_out_neg", 32'(e_out_neg), 1);
    e_out_ready = 1'b1; tick(); e_out_ready = 1'b0;

    e_in_tt = 16'hAAAA; e_in_valid = 1'b1;
    tick();
    e_in_valid = 1'b0;
    cyc = 0;
    while (!e_out_valid && cyc < 500) begin
      tick();
      cyc++;
    end
    check("eeA_latency", 32'(cyc), 384);
    check("eeA_canon", 32'(e_canon_tt), 32'h00FF);
    check("eeA_perm", 32'(e_perm_idx), 9);
    e_out_ready = 1'b1; tick(); e_out_ready = 1'b0;

    // Main instance, hand-computed directed vectors.
    run_main(16'h0000); check_result("z", 16'h0000, 0, 4'h0, 1'b0); release_main();
    run_main(16'hFFFF); check_result("f", 16'h0000, 0, 4'h0, 1'b1); release_main();
    run_main(16'hAAAA); check_result("x0", 16'h00FF, 9, 4'h0, 1'b1);
    check("x0_reapply", 32'(apply_tf(16'hAAAA, int'(perm_idx), in_neg, out_neg)), 32'h00FF);
    release_main();
    run_main(16'h8888); check_result("and", 16'h000F, 16, 4'hC, 1'b0);
    check("and_reapply", 32'(apply_tf(16'h8888, int'(perm_idx), in_neg, out_neg)), 32'h000F);
    release_main();
    run_main(16'h7777); check_result("nand", 16'h000F, 16, 4'hC, 1'b1);
    check("nand_reapply", 32'(apply_tf(16'h7777, int'(perm_idx), in_neg, out_neg)), 32'h000F);

    // Hold in DONE with input noise; outputs must not move.
    snap_c = canon_tt; snap_p = perm_idx; snap_n = in_neg; snap_o = out_neg;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'($urandom);
      in_tt = 16'($urandom);
      out_ready = 1'b0;
      tick();
      check("hold_stable", 32'({out_valid, canon_tt, perm_idx, in_neg, out_neg}),
            32'({1'b1, snap_c, snap_p, snap_n, snap_o}));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    release_main();
    run_main(16'hAAAA); check_result("after_hold", 16'h00FF, 9, 4'h0, 1'b1); release_main();

    // Reset in the middle of a search discards the run.
    in_tt = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (200) tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_canon", 32'(canon_tt), 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_emit", 32'(seen), 0);
    run_main(16'h1234); check_vs_model("post_rst", 16'h1234); release_main();

    for (int r = 0; r < 15; r++) begin
      rtt = 16'($urandom);
      run_main(rtt);
      check_vs_model($sformatf("rand%0d", r), rtt);
      release_main();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
